// File: rtl/store_write_sequencer.sv
// rtl/store_write_sequencer.sv - lane-positions SB/SH/SW stores and issues word-aligned write beats
//
// Ports:
//   i_clk, i_rst_n             clock, asynchronous active-low reset
//   i_req_valid / o_req_ready  store request handshake from the MA stage
//   i_is_store_byte            SB (takes priority over halfword)
//   i_is_store_halfword        SH (neither flag = SW)
//   i_address, i_store_data    byte address and rs2 value of the store
//   o_mem_valid / i_mem_ready  write beat handshake to data memory
//   o_mem_address              word-aligned beat address
//   o_mem_write_data           lane-positioned beat data (disabled lanes are 0)
//   o_mem_byte_enable          per-byte write enable
//   o_mem_last                 final beat of the current request
//   o_busy                     a request is held
module store_write_sequencer #(
  parameter int XLEN = 32
) (
  input  logic              i_clk,
  input  logic              i_rst_n,
  input  logic              i_req_valid,
  output logic              o_req_ready,
  input  logic              i_is_store_byte,
  input  logic              i_is_store_halfword,
  input  logic [XLEN-1:0]   i_address,
  input  logic [XLEN-1:0]   i_store_data,
  output logic              o_mem_valid,
  input  logic              i_mem_ready,
  output logic [XLEN-1:0]   o_mem_address,
  output logic [XLEN-1:0]   o_mem_write_data,
  output logic [XLEN/8-1:0] o_mem_byte_enable,
  output logic              o_mem_last,
  output logic              o_busy
);

  localparam int BW = XLEN / 8;

  typedef enum logic [1:0] {
    S_IDLE,
    S_LO,
    S_HI
  } state_t;

  state_t state, state_next;

  // Second-beat fields, held until the first beat of a split store is taken.
  logic [XLEN-1:0] hi_address_q;
  logic [XLEN-1:0] hi_data_q;
  logic [BW-1:0]   hi_be_q;
  logic            last_q;

  logic [1:0]        off;
  logic [XLEN-1:0]   src;
  logic [BW-1:0]     base_mask;
  logic [2*XLEN-1:0] wide_data;
  logic [2*BW-1:0]   wide_mask;
  logic              split;
  logic [XLEN-1:0]   lo_address;
  logic [XLEN-1:0]   hi_address;

  logic accept;
  logic beat_done;
  logic final_done;

  // Positioning is done entirely on the request inputs; every beat field is
  // registered so the memory-side outputs come straight from flops.
  always_comb begin
    off       = i_address[1:0];
    src       = i_store_data;
    base_mask = {BW{1'b1}};
    if (i_is_store_byte) begin
      src       = {{(XLEN-8){1'b0}}, i_store_data[7:0]};
      base_mask = {{(BW-1){1'b0}}, 1'b1};
    end else if (i_is_store_halfword) begin
      src       = {{(XLEN-16){1'b0}}, i_store_data[15:0]};
      base_mask = {{(BW-2){1'b0}}, 2'b11};
    end
    wide_data  = {{XLEN{1'b0}}, src} << {off, 3'b000};
    wide_mask  = {{BW{1'b0}}, base_mask} << off;
    split      = |wide_mask[2*BW-1:BW];
    lo_address = {i_address[XLEN-1:2], 2'b00};
    // Natural 30-bit wrap takes 0xFFFFFFFC to 0x00000000.
    hi_address = {i_address[XLEN-1:2] + {{(XLEN-3){1'b0}}, 1'b1}, 2'b00};
  end

  assign o_mem_valid = (state != S_IDLE);
  assign o_busy      = (state != S_IDLE);
  assign o_mem_last  = last_q;

  // Finishing a request frees the buffer in the same cycle, so a new request
  // can be taken back-to-back with the last beat.
  assign o_req_ready = (state == S_IDLE) | (o_mem_valid & o_mem_last & i_mem_ready);
  assign accept      = i_req_valid & o_req_ready;
  assign beat_done   = o_mem_valid & i_mem_ready;
  assign final_done  = beat_done & o_mem_last;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state <= S_IDLE;
    end else begin
      state <= state_next;
    end
  end

  always_comb begin
    state_next = state;
    case (state)
      S_IDLE: begin
        if (accept) state_next = S_LO;
      end
      S_LO, S_HI: begin
        if (beat_done) begin
          if (!last_q)     state_next = S_HI;
          else if (accept) state_next = S_LO;
          else             state_next = S_IDLE;
        end
      end
      default: state_next = S_IDLE;
    endcase
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      o_mem_address     <= '0;
      o_mem_write_data  <= '0;
      o_mem_byte_enable <= '0;
      last_q            <= 1'b0;
      hi_address_q      <= '0;
      hi_data_q         <= '0;
      hi_be_q           <= '0;
    end else if (accept) begin
      o_mem_address     <= lo_address;
      o_mem_write_data  <= wide_data[XLEN-1:0];
      o_mem_byte_enable <= wide_mask[BW-1:0];
      last_q            <= ~split;
      hi_address_q      <= hi_address;
      hi_data_q         <= wide_data[2*XLEN-1:XLEN];
      hi_be_q           <= wide_mask[2*BW-1:BW];
    end else if (beat_done && !last_q) begin
      o_mem_address     <= hi_address_q;
      o_mem_write_data  <= hi_data_q;
      o_mem_byte_enable <= hi_be_q;
      last_q            <= 1'b1;
    end else if (final_done) begin
      o_mem_address     <= '0;
      o_mem_write_data  <= '0;
      o_mem_byte_enable <= '0;
      last_q            <= 1'b0;
    end
  end

endmodule

// File: tb/tb_store_write_sequencer.sv
// tb/tb_store_write_sequencer.sv - directed vector bench for store_write_sequencer
module tb_store_write_sequencer;

  logic        i_clk;
  logic        i_rst_n;
  logic        i_req_valid;
  logic        o_req_ready;
  logic        i_is_store_byte;
  logic        i_is_store_halfword;
  logic [31:0] i_address;
  logic [31:0] i_store_data;
  logic        o_mem_valid;
  logic        i_mem_ready;
  logic [31:0] o_mem_address;
  logic [31:0] o_mem_write_data;
  logic [3:0]  o_mem_byte_enable;
  logic        o_mem_last;
  logic        o_busy;

  store_write_sequencer #(.XLEN(32)) dut (
    .i_clk               (i_clk),
    .i_rst_n             (i_rst_n),
    .i_req_valid         (i_req_valid),
    .o_req_ready         (o_req_ready),
    .i_is_store_byte     (i_is_store_byte),
    .i_is_store_halfword (i_is_store_halfword),
    .i_address           (i_address),
    .i_store_data        (i_store_data),
    .o_mem_valid         (o_mem_valid),
    .i_mem_ready         (i_mem_ready),
    .o_mem_address       (o_mem_address),
    .o_mem_write_data    (o_mem_write_data),
    .o_mem_byte_enable   (o_mem_byte_enable),
    .o_mem_last          (o_mem_last),
    .o_busy              (o_busy)
  );

  initial i_clk = 1'b0;
  always #5 i_clk = ~i_clk;

  int tests = 0;
  int fails = 0;

  typedef struct {
    logic        sb;
    logic        sh;
    logic [31:0] addr;
    logic [31:0] data;
    int          beats;
    logic [31:0] a0;
    logic [31:0] d0;
    logic [3:0]  e0;
    logic [31:0] a1;
    logic [31:0] d1;
    logic [3:0]  e1;
  } vec_t;

  vec_t vecs [11];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic chk_beat(input string name, input logic [31:0] a, input logic [31:0] d,
                          input logic [3:0] e, input logic last);
    chk({name, "_valid"}, 32'(o_mem_valid), 32'd1);
    chk({name, "_addr"}, o_mem_address, a);
    chk({name, "_data"}, o_mem_write_data, d);
    chk({name, "_be"}, 32'(o_mem_byte_enable), 32'(e));
    chk({name, "_last"}, 32'(o_mem_last), 32'(last));
  endtask

  task automatic drive_req(input logic sb, input logic sh, input logic [31:0] a, input logic [31:0] d);
    i_req_valid         = 1'b1;
    i_is_store_byte     = sb;
    i_is_store_halfword = sh;
    i_address           = a;
    i_store_data        = d;
  endtask

  // Drop the request and scramble its fields to show they are not re-sampled.
  task automatic drop_req();
    i_req_valid         = 1'b0;
    i_is_store_byte     = 1'($urandom);
    i_is_store_halfword = 1'($urandom);
    i_address           = $urandom;
    i_store_data        = $urandom;
  endtask

  task automatic run_vec(input vec_t v, input int idx);
    string n;
    n = $sformatf("vec%0d", idx);
    @(negedge i_clk);
    i_mem_ready = 1'b1;
    drive_req(v.sb, v.sh, v.addr, v.data);
    #1;
    chk({n, "_ready_idle"}, 32'(o_req_ready), 32'd1);
    @(negedge i_clk);
    drop_req();
    #1;
    chk_beat({n, "_b0"}, v.a0, v.d0, v.e0, v.beats == 1);
    chk({n, "_b0_ready"}, 32'(o_req_ready), 32'(v.beats == 1));
    if (v.beats == 2) begin
      @(negedge i_clk);
      #1;
      chk_beat({n, "_b1"}, v.a1, v.d1, v.e1, 1'b1);
      chk({n, "_b1_ready"}, 32'(o_req_ready), 32'd1);
    end
    @(negedge i_clk);
    #1;
    chk({n, "_done_valid"}, 32'(o_mem_valid), 32'd0);
    chk({n, "_done_busy"}, 32'(o_busy), 32'd0);
  endtask

  initial begin
    vecs[0]  = '{1'b1, 1'b0, 32'h0000_1001, 32'hFFFF_FFAB, 1, 32'h0000_1000, 32'h0000_AB00, 4'b0010, 32'h0, 32'h0, 4'h0};
    vecs[1]  = '{1'b0, 1'b0, 32'h0000_1003, 32'hDDCC_BBAA, 2, 32'h0000_1000, 32'hAA00_0000, 4'b1000, 32'h0000_1004, 32'h00DD_CCBB, 4'b0111};
    vecs[2]  = '{1'b0, 1'b0, 32'hFFFF_FFFE, 32'h1122_3344, 2, 32'hFFFF_FFFC, 32'h3344_0000, 4'b1100, 32'h0000_0000, 32'h0000_1122, 4'b0011};
    vecs[3]  = '{1'b0, 1'b1, 32'h0000_2002, 32'hABCD_5678, 1, 32'h0000_2000, 32'h5678_0000, 4'b1100, 32'h0, 32'h0, 4'h0};
    vecs[4]  = '{1'b0, 1'b1, 32'h0000_2003, 32'h0000_1234, 2, 32'h0000_2000, 32'h3400_0000, 4'b1000, 32'h0000_2004, 32'h0000_0012, 4'b0001};
    vecs[5]  = '{1'b0, 1'b0, 32'h0000_3000, 32'hCAFE_BABE, 1, 32'h0000_3000, 32'hCAFE_BABE, 4'b1111, 32'h0, 32'h0, 4'h0};
    vecs[6]  = '{1'b1, 1'b1, 32'h0000_4003, 32'h1234_5678, 1, 32'h0000_4000, 32'h7800_0000, 4'b1000, 32'h0, 32'h0, 4'h0};
    vecs[7]  = '{1'b1, 1'b0, 32'h0000_4000, 32'h0000_00FF, 1, 32'h0000_4000, 32'h0000_00FF, 4'b0001, 32'h0, 32'h0, 4'h0};
    vecs[8]  = '{1'b0, 1'b0, 32'h0000_5001, 32'h0102_0304, 2, 32'h0000_5000, 32'h0203_0400, 4'b1110, 32'h0000_5004, 32'h0000_0001, 4'b0001};
    vecs[9]  = '{1'b0, 1'b0, 32'h0000_5002, 32'h0102_0304, 2, 32'h0000_5000, 32'h0304_0000, 4'b1100, 32'h0000_5004, 32'h0000_0102, 4'b0011};
    vecs[10] = '{1'b0, 1'b1, 32'h0000_6001, 32'hFFFF_8001, 1, 32'h0000_6000, 32'h0080_0100, 4'b0110, 32'h0, 32'h0, 4'h0};

    i_rst_n             = 1'b0;
    i_req_valid         = 1'b0;
    i_is_store_byte     = 1'b0;
    i_is_store_halfword = 1'b0;
    i_address           = '0;
    i_store_data        = '0;
    i_mem_ready         = 1'b0;
    repeat (2) @(negedge i_clk);
    #1;
    chk("rst_valid", 32'(o_mem_valid), 32'd0);
    chk("rst_last", 32'(o_mem_last), 32'd0);
    chk("rst_busy", 32'(o_busy), 32'd0);
    chk("rst_addr", o_mem_address, 32'd0);
    chk("rst_data", o_mem_write_data, 32'd0);
    chk("rst_be", 32'(o_mem_byte_enable), 32'd0);
    @(negedge i_clk);
    i_rst_n = 1'b1;
    #1;
    chk("rst_ready", 32'(o_req_ready), 32'd1);

    for (int i = 0; i < 11; i++) run_vec(vecs[i], i);

    // Split SH with three stall cycles on each beat.
    @(negedge i_clk);
    i_mem_ready = 1'b0;
    drive_req(1'b0, 1'b1, 32'h0000_2003, 32'h0000_1234);
    for (int s = 0; s < 3; s++) begin
      @(negedge i_clk);
      if (s == 0) drop_req();
      #1;
      chk_beat($sformatf("stall_b0_s%0d", s), 32'h0000_2000, 32'h3400_0000, 4'b1000, 1'b0);
      chk($sformatf("stall_b0_s%0d_ready", s), 32'(o_req_ready), 32'd0);
    end
    @(negedge i_clk);
    i_mem_ready = 1'b1;
    #1;
    chk_beat("stall_b0_take", 32'h0000_2000, 32'h3400_0000, 4'b1000, 1'b0);
    chk("stall_b0_take_ready", 32'(o_req_ready), 32'd0);
    for (int s = 0; s < 3; s++) begin
      @(negedge i_clk);
      i_mem_ready = 1'b0;
      #1;
      chk_beat($sformatf("stall_b1_s%0d", s), 32'h0000_2004, 32'h0000_0012, 4'b0001, 1'b1);
      chk($sformatf("stall_b1_s%0d_ready", s), 32'(o_req_ready), 32'd0);
    end
    @(negedge i_clk);
    i_mem_ready = 1'b1;
    #1;
    chk_beat("stall_b1_take", 32'h0000_2004, 32'h0000_0012, 4'b0001, 1'b1);
    chk("stall_b1_take_ready", 32'(o_req_ready), 32'd1);
    @(negedge i_clk);
    #1;
    chk("stall_done_valid", 32'(o_mem_valid), 32'd0);

    // Four aligned SW back-to-back: one beat per cycle, no bubble.
    for (int k = 0; k <= 4; k++) begin
      logic [31:0] exp_d;
      @(negedge i_clk);
      i_mem_ready = 1'b1;
      if (k < 4) drive_req(1'b0, 1'b0, 32'(4 * k), {4{8'(k + 1)}});
      else       drop_req();
      #1;
      if (k > 0) begin
        exp_d = {4{8'(k)}};
        chk_beat($sformatf("b2b_%0d", k - 1), 32'(4 * (k - 1)), exp_d, 4'b1111, 1'b1);
      end
      chk($sformatf("b2b_%0d_ready", k), 32'(o_req_ready), 32'd1);
    end
    @(negedge i_clk);
    #1;
    chk("b2b_done_valid", 32'(o_mem_valid), 32'd0);

    // Reset in the LO beat of a split SW.
    @(negedge i_clk);
    i_mem_ready = 1'b0;
    drive_req(1'b0, 1'b0, 32'h0000_7001, 32'h5566_7788);
    @(negedge i_clk);
    drop_req();
    #1;
    chk_beat("rstmid_b0", 32'h0000_7000, 32'h6677_8800, 4'b1110, 1'b0);
    #1;
    i_rst_n     = 1'b0;
    i_mem_ready = 1'b1;
    #1;
    chk("rstmid_valid", 32'(o_mem_valid), 32'd0);
    chk("rstmid_addr", o_mem_address, 32'd0);
    chk("rstmid_data", o_mem_write_data, 32'd0);
    chk("rstmid_be", 32'(o_mem_byte_enable), 32'd0);
    chk("rstmid_last", 32'(o_mem_last), 32'd0);
    chk("rstmid_busy", 32'(o_busy), 32'd0);
    @(negedge i_clk);
    i_rst_n     = 1'b1;
    i_req_valid = 1'b0;
    #1;
    chk("rstmid_rel_ready", 32'(o_req_ready), 32'd1);
    chk("rstmid_rel_valid", 32'(o_mem_valid), 32'd0);
    for (int c = 0; c < 3; c++) begin
      @(negedge i_clk);
      #1;
      chk($sformatf("rstmid_nohi_%0d", c), 32'(o_mem_valid), 32'd0);
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
